secuenciador_operandos: RTL and testbench

Sequencer that walks a contiguous address range of the two 8x32 operand memories (A and B, combinational read). For each element it applies one ALU operation and hands the result downstream over a valid/ready handshake. It sits between the operand memories, the combinational ALU and the result consumer (register file or display logic). Start/busy/done control comes from the top-level controller.

---
 rtl/secuenciador_pkg.sv | 23 ++
 rtl/secuenciador_operandos.sv | 119 +++++++++++
 tb/tb_secuenciador_operandos.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/secuenciador_pkg.sv
// Shared definitions for the operand sequencer: state encoding, default widths
// and the ALU opcode map that the ALU and the sequencer agree on.
package secuenciador_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int OP_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } estado_t;

  localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [OP_W-1:0] ALU_XOR = 4'd4;

endpackage

// File: rtl/secuenciador_operandos.sv
// Walks a contiguous address range of the A/B operand memories, registers each
// operand pair for the ALU and hands every result downstream via valid/ready.
module secuenciador_operandos #(
  parameter int DATA_W = secuenciador_pkg::DATA_W,
  parameter int ADDR_W = secuenciador_pkg::ADDR_W,
  parameter int OP_W   = secuenciador_pkg::OP_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] first_addr_i,
  input  logic [ADDR_W:0]   count_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [ADDR_W-1:0] addr_a_o,
  output logic [ADDR_W-1:0] addr_b_o,
  input  logic [DATA_W-1:0] operando_a_i,
  input  logic [DATA_W-1:0] operando_b_i,
  output logic [OP_W-1:0]   alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] resultado_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic [ADDR_W-1:0] res_addr_o,
  output logic              busy_o,
  output logic              done_o
);

  import secuenciador_pkg::*;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] ONE_CNT = (ADDR_W+1)'(1);

  estado_t           state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;
  logic [ADDR_W:0]   count_sat;
  logic              last_elem;

  // Requests larger than the memory depth are clipped to one full sweep.
  assign count_sat = (count_i > MAX_CNT) ? MAX_CNT : count_i;
  assign last_elem = (rem_q == ONE_CNT);

  assign addr_a_o    = addr_q;
  assign addr_b_o    = addr_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign res_valid_o = (state_q == ST_OUT);
  assign done_o      = (state_q == ST_DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = (count_i == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_OUT;
      ST_OUT: begin
        if (res_ready_i) begin
          state_d = last_elem ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath registers; operand and result registers hold their last value
  // once the run is over.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      rem_q      <= '0;
      alu_op_o   <= '0;
      alu_a_o    <= '0;
      alu_b_o    <= '0;
      res_data_o <= '0;
      res_addr_o <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            addr_q   <= first_addr_i;
            rem_q    <= count_sat;
            alu_op_o <= op_i;
          end
        end
        ST_FETCH: begin
          alu_a_o <= operando_a_i;
          alu_b_o <= operando_b_i;
        end
        ST_EXEC: begin
          res_data_o <= resultado_i;
          res_addr_o <= addr_q;
        end
        ST_OUT: begin
          if (res_ready_i && !last_elem) begin
            rem_q  <= rem_q - ONE_CNT;
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_operandos.sv
// Scoreboard bench for the operand sequencer: directed runs push hand-computed
// results, a negedge monitor pops them on every accepted handshake.
module tb_secuenciador_operandos;

  import secuenciador_pkg::*;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int OW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] first_addr_i = '0;
  logic [AW:0]   count_i = '0;
  logic [OW-1:0] op_i = '0;
  logic [AW-1:0] addr_a_o, addr_b_o;
  logic [DW-1:0] operando_a_i, operando_b_i;
  logic [OW-1:0] alu_op_o;
  logic [DW-1:0] alu_a_o, alu_b_o;
  logic [DW-1:0] resultado_i;
  logic          res_valid_o;
  logic          res_ready_i = 1'b1;
  logic [DW-1:0] res_data_o;
  logic [AW-1:0] res_addr_o;
  logic          busy_o, done_o;

  logic [DW-1:0] mem_a [8];
  logic [DW-1:0] mem_b [8];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   doneCount = 0;
  bit   doneLast = 1'b0;

  secuenciador_operandos dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .first_addr_i (first_addr_i),
    .count_i      (count_i),
    .op_i         (op_i),
    .addr_a_o     (addr_a_o),
    .addr_b_o     (addr_b_o),
    .operando_a_i (operando_a_i),
    .operando_b_i (operando_b_i),
    .alu_op_o     (alu_op_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .resultado_i  (resultado_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_data_o   (res_data_o),
    .res_addr_o   (res_addr_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  assign operando_a_i = mem_a[addr_a_o];
  assign operando_b_i = mem_b[addr_b_o];

  always_comb begin
    resultado_i = '0;
    case (alu_op_o)
      ALU_ADD: resultado_i = alu_a_o + alu_b_o;
      ALU_SUB: resultado_i = alu_a_o - alu_b_o;
      ALU_AND: resultado_i = alu_a_o & alu_b_o;
      ALU_OR:  resultado_i = alu_a_o | alu_b_o;
      ALU_XOR: resultado_i = alu_a_o ^ alu_b_o;
      default: resultado_i = '0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic flagFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  task automatic pushExpected(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [AW-1:0] first, input logic [AW:0] cnt, input logic [OW-1:0] op);
    start_i      = 1'b1;
    first_addr_i = first;
    count_i      = cnt;
    op_i         = op;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic waitValid(input bit atLeastOne, output int n);
    n = 0;
    if (atLeastOne) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    while (!res_valid_o && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (!res_valid_o) flagFail("wait_valid");
  endtask

  // Leaves the bench one edge past DONE, i.e. back in IDLE.
  task automatic waitDone(input int maxCycles);
    int k;
    k = 0;
    while (!done_o && k < maxCycles) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    if (!done_o) flagFail("wait_done");
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard monitor: each accepted handshake must match the oldest expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (res_valid_o && res_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_result actual=addr%0d/0x%0h required=none", res_addr_o, res_data_o);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_data", 64'(res_data_o), 64'(e.data));
        checkOutput("sb_addr", 64'(res_addr_o), 64'(e.addr));
      end
    end
    if (done_o) begin
      doneCount++;
      if (doneLast) begin
        checks++;
        failures++;
        $display("[TB] FAIL done_width actual=2+ cycles required=1 cycle");
      end
    end
    doneLast = done_o;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int n;
    int doneBefore;

    mem_a[0] = 32'h0000FFFF; mem_b[0] = 32'hFF00FF00;
    mem_a[1] = 32'hFFFFFFFF; mem_b[1] = 32'h350F6993;
    mem_a[2] = 32'h12340000; mem_b[2] = 32'h00005678;
    mem_a[3] = 32'h0F0F0F0F; mem_b[3] = 32'hF0F0F0F0;
    mem_a[4] = 32'h80000000; mem_b[4] = 32'h80000000;
    mem_a[5] = 32'h00000001; mem_b[5] = 32'hFFFFFFFF;
    mem_a[6] = 32'hAAAAAAAA; mem_b[6] = 32'h55555555;
    mem_a[7] = 32'h7FFFFFFF; mem_b[7] = 32'h00000001;

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_busy", 64'(busy_o), 64'(0));
    checkOutput("reset_valid", 64'(res_valid_o), 64'(0));
    checkOutput("reset_done", 64'(done_o), 64'(0));
    checkOutput("reset_data", 64'(res_data_o), 64'(0));
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    $display("[TB] single element AND");
    pushExpected(3'd0, 32'h0000FF00);
    applyStimulus(3'd0, 4'd1, ALU_AND);
    waitValid(1'b0, n);
    checkOutput("single_latency", 64'(n + 1), 64'(3));
    checkOutput("single_data", 64'(res_data_o), 64'h0000FF00);
    checkOutput("single_addr", 64'(res_addr_o), 64'(0));
    @(posedge clk_i);
    #1;
    checkOutput("single_done", 64'(done_o), 64'(1));
    @(posedge clk_i);
    #1;
    checkOutput("single_done_end", 64'(done_o), 64'(0));
    checkOutput("single_idle", 64'(busy_o), 64'(0));

    $display("[TB] two elements, ready held high");
    pushExpected(3'd0, 32'h0000FF00);
    pushExpected(3'd1, 32'h350F6993);
    applyStimulus(3'd0, 4'd2, ALU_AND);
    waitValid(1'b0, n);
    checkOutput("two_latency", 64'(n + 1), 64'(3));
    waitValid(1'b1, n);
    checkOutput("two_throughput", 64'(n), 64'(3));
    checkOutput("two_data", 64'(res_data_o), 64'h350F6993);
    checkOutput("two_addr", 64'(res_addr_o), 64'(1));
    waitDone(10);

    $display("[TB] address wrap XOR");
    pushExpected(3'd6, 32'hFFFFFFFF);
    pushExpected(3'd7, 32'h7FFFFFFE);
    pushExpected(3'd0, 32'hFF0000FF);
    pushExpected(3'd1, 32'hCAF0966C);
    applyStimulus(3'd6, 4'd4, ALU_XOR);
    waitDone(40);
    checkOutput("wrap_drained", 64'(sb.size()), 64'(0));

    $display("[TB] count 9 saturates to 8, ADD");
    pushExpected(3'd3, 32'hFFFFFFFF);
    pushExpected(3'd4, 32'h00000000);
    pushExpected(3'd5, 32'h00000000);
    pushExpected(3'd6, 32'hFFFFFFFF);
    pushExpected(3'd7, 32'h80000000);
    pushExpected(3'd0, 32'hFF01FEFF);
    pushExpected(3'd1, 32'h350F6992);
    pushExpected(3'd2, 32'h12345678);
    applyStimulus(3'd3, 4'd9, ALU_ADD);
    waitDone(60);
    checkOutput("sat_drained", 64'(sb.size()), 64'(0));

    $display("[TB] backpressure with ignored start");
    res_ready_i = 1'b0;
    pushExpected(3'd2, 32'h12345678);
    pushExpected(3'd3, 32'hFFFFFFFF);
    applyStimulus(3'd2, 4'd2, ALU_OR);
    waitValid(1'b0, n);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", 64'(res_valid_o), 64'(1));
      checkOutput("bp_data", 64'(res_data_o), 64'h12345678);
      checkOutput("bp_addr", 64'(addr_a_o), 64'(2));
      if (i == 2) begin
        start_i      = 1'b1;
        first_addr_i = 3'd5;
        count_i      = 4'd1;
        op_i         = ALU_AND;
      end
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
    end
    checkOutput("bp_op_kept", 64'(alu_op_o), 64'(ALU_OR));
    checkOutput("bp_res_addr", 64'(res_addr_o), 64'(2));
    res_ready_i = 1'b1;
    waitDone(20);
    checkOutput("bp_drained", 64'(sb.size()), 64'(0));

    $display("[TB] count zero");
    applyStimulus(3'd5, 4'd0, ALU_AND);
    checkOutput("zero_done", 64'(done_o), 64'(1));
    checkOutput("zero_valid", 64'(res_valid_o), 64'(0));
    @(posedge clk_i);
    #1;
    checkOutput("zero_done_end", 64'(done_o), 64'(0));
    checkOutput("zero_idle", 64'(busy_o), 64'(0));

    $display("[TB] reset while holding a result");
    res_ready_i = 1'b0;
    applyStimulus(3'd0, 4'd3, ALU_AND);
    waitValid(1'b0, n);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_valid", 64'(res_valid_o), 64'(0));
    checkOutput("rst_busy", 64'(busy_o), 64'(0));
    checkOutput("rst_done", 64'(done_o), 64'(0));
    checkOutput("rst_data", 64'(res_data_o), 64'(0));
    checkOutput("rst_res_addr", 64'(res_addr_o), 64'(0));
    checkOutput("rst_alu_a", 64'(alu_a_o), 64'(0));
    checkOutput("rst_alu_b", 64'(alu_b_o), 64'(0));
    checkOutput("rst_alu_op", 64'(alu_op_o), 64'(0));
    checkOutput("rst_addr", 64'(addr_a_o), 64'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    res_ready_i = 1'b1;
    doneBefore = doneCount;
    repeat (5) @(posedge clk_i);
    #1;
    checkOutput("post_rst_busy", 64'(busy_o), 64'(0));
    checkOutput("post_rst_valid", 64'(res_valid_o), 64'(0));
    checkOutput("post_rst_no_done", 64'(doneCount), 64'(doneBefore));

    checkOutput("final_drained", 64'(sb.size()), 64'(0));
    checkOutput("done_total", 64'(doneCount), 64'(6));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
